// File: rtl/alu_mul_seq_if.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_if
// Operand / result handshake bundle for the shift-and-add multiplier sequencer.
//   in_valid / in_ready   : operand handshake (producer -> sequencer)
//   in_a / in_b           : multiplicand / multiplier, sampled on accept
//   out_valid / out_ready : result handshake (sequencer -> consumer)
//   out_result            : low XLEN bits of in_a * in_b
// Modports: master = issuing side of the core, slave = the sequencer.
// -----------------------------------------------------------------------------
interface alu_mul_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle shift-and-add MUL sequencer that borrows the core's shared ALU.
// Each BUSY cycle issues one ALU add (acc + partial product) and shifts the
// multiplicand left / multiplier right. Iteration stops as soon as no set
// multiplier bits remain, so an operation takes max(1, msb(in_b)+1) BUSY cycles.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : operand/result handshake (alu_mul_seq_if.slave)
//   busy         : high while BUSY or DONE; core muxes ALU inputs to this block
//   alu_a/alu_b  : ALU operands, zero outside BUSY
//   alu_control  : ALU op select, always add (3'b000)
//   alu_result   : combinational ALU result
// -----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_mul_seq_if.slave         bus,
    output logic                 busy,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [2:0]           alu_control,
    input  logic [XLEN-1:0]      alu_result
);

    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        busy         = 1'b0;
        alu_a        = '0;
        alu_b        = '0;

        unique case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    acc_d    = '0;
                    mcand_d  = bus.in_a;
                    mplier_d = bus.in_b;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                busy     = 1'b1;
                alu_a    = acc_q;
                alu_b    = mplier_q[0] ? mcand_q : '0;
                acc_d    = alu_result;
                mcand_d  = {mcand_q[XLEN-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                // Early exit: once the remaining multiplier bits are all zero,
                // further iterations would only add zero.
                if (mplier_q[XLEN-1:1] == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                // in_ready stays low here, forcing one IDLE bubble after the
                // result handshake.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // acc is frozen in DONE, so it serves directly as the held result.
    assign bus.out_result = acc_q;
    assign alu_control    = ALU_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
// Bench for alu_mul_seq: provides the shared ALU, a vector table, hand-written
// corner sequences (output stall, reset abort, back-to-back) and random ops
// checked against a plain-arithmetic reference.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;

    localparam int XLEN = 32;
    localparam int TMO  = 200;

    logic            clk;
    logic            rst;
    logic            busy;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] alu_result;

    int total;
    int bad;

    logic saw_alu_b_nz;
    logic saw_ctl_nz;

    alu_mul_seq_if #(.XLEN(XLEN)) bus ();

    alu_mul_seq #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    // Shared ALU: add / sub / and / or
    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_n;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
    endfunction

    function automatic int ref_n(input logic [31:0] b);
        int n;
        n = 1;
        while (n < 32 && (b >> n) != 32'd0) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold in_valid until the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < TMO) begin
            step();
            guard++;
        end
        check("accept_timeout", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int edges);
        edges        = 0;
        saw_alu_b_nz = 1'b0;
        saw_ctl_nz   = 1'b0;
        while (!bus.out_valid && edges < TMO) begin
            if (alu_b != '0) saw_alu_b_nz = 1'b1;
            if (alu_control != 3'b000) saw_ctl_nz = 1'b1;
            step();
            edges++;
        end
        check("done_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic take_result(input int stall, output logic [31:0] res);
        res = bus.out_result;
        bus.out_ready = 1'b0;
        for (int i = 0; i < stall; i++) step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int          edges;
        logic [31:0] res;
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        pulsed;

        total = 0;
        bad   = 0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{32'd5,        32'd7,        32'd35,       3};
        vecs[1] = '{32'hDEADBEEF, 32'd0,        32'd0,        1};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32};
        vecs[3] = '{32'hFFFFFFFD, 32'd4,        32'hFFFFFFF4, 3};
        vecs[4] = '{32'd6,        32'd9,        32'd54,       4};
        vecs[5] = '{32'd1,        32'h80000000, 32'h80000000, 32};
        vecs[6] = '{32'h00012345, 32'd1,        32'h00012345, 1};

        // Reset state
        rst = 1'b1;
        #2;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_alu_a",     alu_a,              32'd0);
        check("rst_alu_b",     alu_b,              32'd0);
        check("rst_alu_ctl",   32'(alu_control),   32'd0);
        check("rst_result",    bus.out_result,     32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Vector table: result and latency (out_valid N edges after accept,
        // i.e. cycle N+1 when the accept cycle is cycle 0)
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_done(edges);
            check($sformatf("v%0d_latency", i), 32'(edges), 32'(vecs[i].exp_n));
            check($sformatf("v%0d_ctl", i), 32'(saw_ctl_nz), 32'd0);
            if (vecs[i].b == 32'd0)
                check($sformatf("v%0d_alu_b_quiet", i), 32'(saw_alu_b_nz), 32'd0);
            take_result(0, res);
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_idle_ready", i), 32'(bus.in_ready), 32'd1);
            check($sformatf("v%0d_idle_valid", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("v%0d_idle_alu_a", i), alu_a, 32'd0);
        end

        // Stalled consumer: result held, new in_valid ignored, bubble enforced
        start_op(32'hFFFFFFFD, 32'd4);
        wait_done(edges);
        held = bus.out_result;
        check("stall_result", held, 32'hFFFFFFF4);
        bus.in_a     = 32'd11;
        bus.in_b     = 32'd13;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_hold",  bus.out_result, held);
            check("stall_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("stall_bubble_valid", 32'(bus.out_valid), 32'd0);
        check("stall_bubble_busy",  32'(busy), 32'd0);
        check("stall_bubble_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("stall_next_accept", 32'(busy), 32'd1);
        wait_done(edges);
        take_result(0, res);
        check("stall_next_result", res, 32'd143);

        // Reset mid-BUSY aborts the op
        start_op(32'h12345678, 32'hFFFFFFFF);
        for (int i = 0; i < 9; i++) step();
        check("abort_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_busy",      32'(busy),          32'd0);
        check("abort_alu_a",     alu_a,              32'd0);
        check("abort_alu_b",     alu_b,              32'd0);
        check("abort_result",    bus.out_result,     32'd0);
        step();
        rst = 1'b0;
        pulsed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) pulsed = 1'b1;
            step();
        end
        check("abort_no_pulse", 32'(pulsed), 32'd0);
        start_op(32'd6, 32'd9);
        wait_done(edges);
        take_result(0, res);
        check("abort_after_result", res, 32'd54);

        // Back-to-back: in_valid held high across two ops
        bus.in_a     = 32'd1000;
        bus.in_b     = 32'd77;
        bus.in_valid = 1'b1;
        step();
        check("b2b_first_accept", 32'(busy), 32'd1);
        bus.in_a = 32'hFFFFFFFE;
        bus.in_b = 32'd3;
        wait_done(edges);
        check("b2b_first_result", bus.out_result, 32'd77000);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("b2b_bubble_busy",  32'(busy), 32'd0);
        check("b2b_bubble_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("b2b_second_accept", 32'(busy), 32'd1);
        wait_done(edges);
        take_result(0, res);
        check("b2b_second_result", res, 32'hFFFFFFFA);

        // Random ops against the reference model
        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            start_op(ra, rb);
            wait_done(edges);
            check($sformatf("rnd%0d_latency", i), 32'(edges), 32'(ref_n(rb)));
            take_result(int'($urandom_range(0, 2)), res);
            check($sformatf("rnd%0d_result", i), res, ref_mul(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle shift-and-add multiplier sequencer that borrows the core's shared ALU (add/sub/and/or) to compute MUL. It takes two XLEN operands via a valid/ready handshake and drives the ALU add operation once per iteration. It returns the low XLEN bits of the product via a valid/ready handshake. It sits beside the ALU in the execute stage; the core muxes ALU inputs to this block while busy is high.

Parameters:
XLEN, 32, operand/result width in bits (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands (high only in IDLE)
in_a  input  XLEN  multiplicand
in_b  input  XLEN  multiplier
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  XLEN  low XLEN bits of in_a*in_b
busy  output  1  high in BUSY and DONE
alu_a  output  XLEN  ALU operand a
alu_b  output  XLEN  ALU operand b
alu_control  output  3  ALU op select
alu_result  input  XLEN  combinational ALU result

Behaviour:
- Clock/reset: one clock, clk; rst is asynchronous, active-high. Reset forces state IDLE and clears acc, mcand, mplier and out_result to 0. Outputs during/after reset: in_ready=1, out_valid=0, busy=0, alu_a=0, alu_b=0, alu_control=3'b000.
- ALU encoding used: 3'b000 = add. Only add is issued; alu_control is constant 3'b000.
- Registers:
  - acc (XLEN)
  - mcand (XLEN)
  - mplier (XLEN)
  - FSM state: IDLE, BUSY, DONE
- IDLE:
  - in_ready=1; alu_a=alu_b=0.
  - On in_valid: acc<=0, mcand<=in_a, mplier<=in_b, go to BUSY.
- BUSY, one iteration per cycle:
  - alu_a=acc; alu_b = mplier[0] ? mcand : 0.
  - acc<=alu_result; mcand<=mcand<<1 (MSB dropped); mplier<=mplier>>1 (zero fill).
  - Exit to DONE when the shifted mplier (mplier>>1) is 0. Else stay in BUSY.
- BUSY cycle count: N = max(1, index_of_msb(in_b)+1). in_b=0 gives N=1; in_b with bit XLEN-1 set gives N=XLEN. No separate counter is needed; early exit is the termination rule.
- DONE:
  - out_valid=1; out_result=acc, held stable until handshake.
  - On out_ready: go to IDLE. out_valid drops the next cycle.
  - in_ready=0 in DONE, so a new op cannot be accepted in the same cycle as the result handshake. There is a mandatory one-cycle IDLE bubble.
- Latency: with the accept edge as cycle 0, out_valid rises at cycle N+1 (first edge after the last BUSY edge).
- Arithmetic: all modulo 2^XLEN; overflow bits are discarded. The result is correct for both signed and unsigned interpretation of the low product bits (two's complement).
- in_valid outside IDLE is ignored; in_a/in_b are sampled only on the accept edge.
- out_ready outside DONE is ignored.
- alu_a/alu_b are 0 outside BUSY, so the shared ALU sees a quiet bus.
- rst asserted mid-BUSY or mid-DONE aborts the op: immediate return to reset values, with no out_valid pulse for the aborted op.

Test Plan:
- XLEN=32, in_a=5, in_b=7, out_ready=1 -> busy high, BUSY 3 cycles, out_valid at cycle 4 with out_result=35, then IDLE, in_ready=1.
- in_a=32'hDEADBEEF, in_b=0 -> BUSY 1 cycle, out_valid at cycle 2, out_result=0; alu_b=0 throughout.
- in_a=in_b=32'hFFFFFFFF -> BUSY 32 cycles, out_valid at cycle 33, out_result=32'h00000001.
- in_a=32'hFFFFFFFD (-3), in_b=4 -> BUSY 3 cycles, out_result=32'hFFFFFFF4 (-12). Hold out_ready=0 for 5 cycles: out_valid and out_result stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next cycle, next op accepted one cycle later.
- Start 32'h12345678*32'hFFFFFFFF, assert rst at BUSY cycle 10 -> all outputs at reset values asynchronously, no out_valid. After release, 6*9 -> out_result=54.
- Back-to-back: in_valid held high with new operands -> the second op is accepted only on the cycle after the first result handshake, and both results are correct.
